bist_session_ctrl: RTL and testbench
====================================

# bist_session_ctrl

Multi-session BIST sequencer that drives the shared pattern-generator/MISR datapath around the circuit under test. One `start` runs NSESS back-to-back test sessions. Each session runs NCLOCK pattern cycles, then compares the MISR signature against a per-session golden value. At the end the block reports a sticky pass/fail with `finish`/`bist_end`. It sits between the test-access logic (which issues `start`) and the LFSR/MISR/CUT datapath.

## Interface
Parameters:
- `NCLOCK`, 650: pattern cycles per session; must be ≥ 2.
- `NSESS`, 4: sessions per BIST run; must be ≥ 1.
- `SIG_W`, 16: MISR signature width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE or DONE.
- `misr_sig`  in  SIG_W  current MISR signature from the datapath.
- `golden`  in  SIG_W  expected signature for the session selected by `sess_idx`.
- `init`  out  1  one-cycle pulse: load LFSR seed for `sess_idx` and clear the MISR.
- `running`  out  1  high while patterns are applied; enables LFSR and MISR.
- `toggle`  out  1  one-cycle pulse between sessions; advances the seed/mode.
- `sess_idx`  out  $clog2(NSESS) (min 1)  current session number.
- `finish`  out  1  one-cycle pulse at the end of the run.
- `bist_end`  out  1  level: run complete, result valid.
- `pass`  out  1  valid while `bist_end`=1; 1 means all sessions matched.

## Operation
- Moore FSM with states IDLE, INIT, RUN, CHECK, NEXT, DONE. All outputs decode from registered state and counters.
- IDLE: all outputs 0. `start`=1 → INIT with `sess_idx`=0 and fail flag cleared.
- INIT: `init`=1 for one cycle; cycle counter cleared → RUN.
- RUN: `running`=1 and the counter increments every cycle. At count NCLOCK-1 → CHECK, so `running` is high exactly NCLOCK cycles per session.
- CHECK, one cycle:
  - fail flag |= (`misr_sig` != `golden`).
  - If `sess_idx`==NSESS-1 → DONE, otherwise → NEXT.
- NEXT: `toggle`=1 for one cycle and `sess_idx` increments → INIT.
- DONE:
  - `bist_end`=1 and `pass`=~fail.
  - `finish`=1 only in the first DONE cycle.
  - `start`=1 → INIT, with `sess_idx`=0, fail flag cleared, and `bist_end` deasserting.
- `start` in INIT/RUN/CHECK/NEXT is ignored; the run is neither restarted nor extended.
- Cycle counter width is $clog2(NCLOCK). It never wraps: it is cleared in INIT and stops at NCLOCK-1.

## Timing
- Reset (`reset_n`=0, at any time, including mid-run):
  - Immediately forces IDLE.
  - Counter = 0, `sess_idx` = 0, fail = 0.
  - `init`, `running`, `toggle`, `finish`, `bist_end`, `pass` = 0.
- `start` sampled at edge k → `init` high in cycle k+1 → `running` high from cycle k+2.
- Per session: 1 (INIT) + NCLOCK (RUN) + 1 (CHECK) cycles. NEXT adds 1 cycle between sessions.
- `start` edge → `finish` cycle latency = NSESS·(NCLOCK+2) + (NSESS-1) + 1. Defaults give 2612.
- `misr_sig` is sampled in CHECK, one cycle after the last `running` cycle, so the datapath has one cycle to absorb the final pattern.
- `reset_n` low with `start` high: reset wins. The run begins on the first edge after release where `start`=1.
- `toggle` pulses per run = NSESS-1. `running` cycles per run = NSESS·NCLOCK.

## Structure
- `bist_pkg`:
  - state enum (IDLE…DONE);
  - default `NCLOCK`/`NSESS`/`SIG_W` constants;
  - a `clog2_min1` helper for index widths.
- One sub-module, `bist_cycle_counter`: clear/enable/terminal-count counter parameterised by NCLOCK. It is instantiated once for the RUN count.
- FSM, session index and fail flag stay in `bist_session_ctrl`.

## Test plan
All scenarios use the defaults (NCLOCK=650, NSESS=4, SIG_W=16).
- Normal run: reset, 1-cycle `start`, `golden`==`misr_sig` always → 2600 `running` cycles, 3 `toggle` pulses, 1 `finish` at latency 2612, `bist_end`=1, `pass`=1.
- Mismatch: `golden` differs from `misr_sig` only while `sess_idx`=2 → all 4 sessions still run, `pass`=0 at `bist_end`.
- Mid-run start: second `start` pulse 3 cycles into RUN → no extra `init`, `finish` still at 2612 after the first start.
- Mid-run reset: `reset_n` low 50 ns after `start` → all outputs 0 at once. A new `start` then gives a full 2600-cycle run and `pass`=1.
- Restart from DONE: `start` while `bist_end`=1 → `bist_end` drops, `sess_idx`=0, fail cleared, a full second run with `finish` again at 2612.
- Reset/start overlap: `start` held high across `reset_n` release → `init` asserts exactly one cycle after the first edge with `reset_n`=1.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and defaults for the multi-session BIST sequencer.
// Holds the FSM state encoding, parameter defaults and the index-width helper.
package bist_pkg;

  localparam int NCLOCK_DEF = 650;
  localparam int NSESS_DEF  = 4;
  localparam int SIG_W_DEF  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_CHECK,
    S_NEXT,
    S_DONE
  } bist_state_e;

  // A single-entry range still needs a one-bit index.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bist_session_ctrl_if.sv
// Connection bundle between the BIST sequencer, the test-access logic and the
// LFSR/MISR datapath; also carries the FSM state for observation.
interface bist_session_ctrl_if
  import bist_pkg::*;
#(
  parameter int NSESS = NSESS_DEF,
  parameter int SIG_W = SIG_W_DEF
) ();

  localparam int IW = clog2_min1(NSESS);

  // start is a level request without a ready: it is honoured only while the
  // sequencer sits in IDLE or DONE and ignored otherwise; no backpressure.
  logic             start;
  logic [SIG_W-1:0] misr_sig;
  logic [SIG_W-1:0] golden;
  logic             init;
  logic             running;
  logic             toggle;
  logic [IW-1:0]    sess_idx;
  logic             finish;
  logic             bist_end;
  logic             pass;
  bist_state_e      state;

  modport master (
    input  start, misr_sig, golden,
    output init, running, toggle, sess_idx, finish, bist_end, pass, state
  );

  modport slave (
    output start, misr_sig, golden,
    input  init, running, toggle, sess_idx, finish, bist_end, pass, state
  );

endinterface

// File: rtl/bist_cycle_counter.sv
// Pattern-cycle counter: synchronous clear, enable, saturates at NCLOCK-1.
// tc flags the last pattern cycle of a session.
module bist_cycle_counter
  import bist_pkg::*;
#(
  parameter int NCLOCK = NCLOCK_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = clog2_min1(NCLOCK);

  logic [CW-1:0] count;

  assign tc = (count == CW'(NCLOCK - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/bist_session_ctrl.sv
// Multi-session BIST sequencer: runs NSESS sessions of NCLOCK pattern cycles,
// checks each MISR signature and reports a sticky pass/fail at the end.
module bist_session_ctrl
  import bist_pkg::*;
#(
  parameter int NCLOCK = NCLOCK_DEF,
  parameter int NSESS  = NSESS_DEF,
  parameter int SIG_W  = SIG_W_DEF
) (
  input logic                 clk,
  input logic                 reset_n,
  bist_session_ctrl_if.master bus
);

  localparam int IW = clog2_min1(NSESS);

  bist_state_e      state;
  logic [IW-1:0]    sess;
  logic             fail;
  logic             init_r, running_r, toggle_r, finish_r, bist_end_r, pass_r;
  logic             cnt_tc;
  logic [SIG_W-1:0] sig_diff;
  logic             mismatch;
  logic             last_sess;

  assign sig_diff  = bus.misr_sig ^ bus.golden;
  assign mismatch  = |sig_diff;
  assign last_sess = (sess == IW'(NSESS - 1));

  bist_cycle_counter #(.NCLOCK(NCLOCK)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state == S_INIT),
    .en      (state == S_RUN),
    .tc      (cnt_tc)
  );

  // Outputs are registered alongside the state so each one reflects the
  // state being entered; pulses default low every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      sess       <= '0;
      fail       <= 1'b0;
      init_r     <= 1'b0;
      running_r  <= 1'b0;
      toggle_r   <= 1'b0;
      finish_r   <= 1'b0;
      bist_end_r <= 1'b0;
      pass_r     <= 1'b0;
    end else begin
      init_r   <= 1'b0;
      toggle_r <= 1'b0;
      finish_r <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state      <= S_INIT;
            sess       <= '0;
            fail       <= 1'b0;
            init_r     <= 1'b1;
            bist_end_r <= 1'b0;
            pass_r     <= 1'b0;
          end
        end
        S_INIT: begin
          state     <= S_RUN;
          running_r <= 1'b1;
        end
        S_RUN: begin
          if (cnt_tc) begin
            state     <= S_CHECK;
            running_r <= 1'b0;
          end
        end
        S_CHECK: begin
          fail <= fail | mismatch;
          if (last_sess) begin
            state      <= S_DONE;
            finish_r   <= 1'b1;
            bist_end_r <= 1'b1;
            pass_r     <= ~(fail | mismatch);
          end else begin
            state    <= S_NEXT;
            toggle_r <= 1'b1;
          end
        end
        S_NEXT: begin
          state  <= S_INIT;
          sess   <= sess + IW'(1);
          init_r <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.init     = init_r;
  assign bus.running  = running_r;
  assign bus.toggle   = toggle_r;
  assign bus.sess_idx = sess;
  assign bus.finish   = finish_r;
  assign bus.bist_end = bist_end_r;
  assign bus.pass     = pass_r;
  assign bus.state    = state;

endmodule

// File: tb/tb_bist_session_ctrl.sv
// Self-checking bench for bist_session_ctrl: table of full runs plus
// hand-written reset and restart sequences, finish checked by scoreboard.
module tb_bist_session_ctrl;
  import bist_pkg::*;

  localparam int NCLOCK = 650;
  localparam int NSESS  = 4;
  localparam int SIG_W  = 16;
  localparam int LAT    = NSESS * (NCLOCK + 2) + (NSESS - 1) + 1;

  logic clk;
  logic reset_n;

  bist_session_ctrl_if #(.NSESS(NSESS), .SIG_W(SIG_W)) bus ();

  bist_session_ctrl #(.NCLOCK(NCLOCK), .NSESS(NSESS), .SIG_W(SIG_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Golden differs from the MISR in the chosen bad session, and in every
  // non-CHECK cycle of a run, so only a CHECK-cycle sample can match.
  int bad_sess = -1;
  assign bus.golden = ((int'(bus.sess_idx) == bad_sess) || bus.running || bus.init || bus.toggle)
                      ? (bus.misr_sig ^ 16'h0001) : bus.misr_sig;

  initial begin
    bus.misr_sig = '0;
    forever begin
      @(posedge clk);
      #2 bus.misr_sig = SIG_W'($urandom_range(0, 65535));
    end
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];   // {expected pass, expected finish latency}
  int start_edge = 0;
  int run_cnt = 0, tog_cnt = 0, init_cnt = 0, fin_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.running) run_cnt = run_cnt + 1;
      if (bus.toggle)  tog_cnt = tog_cnt + 1;
      if (bus.init)    init_cnt = init_cnt + 1;
      if (bus.finish) begin
        logic [31:0] e;
        fin_cnt = fin_cnt + 1;
        if (exp_q.size() == 0) begin
          check("unexpected_finish", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("finish_latency", cyc - start_edge + 1, int'(e[30:0]));
          check("finish_pass", int'(bus.pass), int'(e[31]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_counts();
    run_cnt = 0; tog_cnt = 0; init_cnt = 0; fin_cnt = 0;
  endtask

  task automatic do_start(input bit track, input bit exp_pass);
    @(posedge clk);
    #1;
    clear_counts();
    bus.start = 1'b1;
    start_edge = cyc + 1;
    if (track) exp_q.push_back({exp_pass, 31'(LAT)});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("start_init", int'(bus.init), 1);
    check("start_bist_end", int'(bus.bist_end), 0);
    check("start_sess_idx", int'(bus.sess_idx), 0);
    check("start_running", int'(bus.running), 0);
  endtask

  task automatic wait_done(input int exp_run, input int exp_tog, input int exp_init,
                           input bit exp_pass);
    int n = 0;
    while (fin_cnt == 0 && n < LAT + 20) begin
      @(negedge clk);
      n = n + 1;
    end
    check("finish_seen", fin_cnt, 1);
    repeat (3) @(negedge clk);
    check("running_cycles", run_cnt, exp_run);
    check("toggle_pulses", tog_cnt, exp_tog);
    check("init_pulses", init_cnt, exp_init);
    check("finish_pulses", fin_cnt, 1);
    check("done_bist_end", int'(bus.bist_end), 1);
    check("done_pass", int'(bus.pass), int'(exp_pass));
    check("done_state", int'(bus.state), int'(S_DONE));
    check("queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_init"}, int'(bus.init), 0);
    check({tag, "_running"}, int'(bus.running), 0);
    check({tag, "_toggle"}, int'(bus.toggle), 0);
    check({tag, "_finish"}, int'(bus.finish), 0);
    check({tag, "_bist_end"}, int'(bus.bist_end), 0);
    check({tag, "_pass"}, int'(bus.pass), 0);
    check({tag, "_sess_idx"}, int'(bus.sess_idx), 0);
    check({tag, "_state"}, int'(bus.state), int'(S_IDLE));
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int bad;
    bit mid_start;
    int exp_run;
    int exp_tog;
    int exp_init;
    bit exp_pass;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{bad: -1, mid_start: 1'b0, exp_run: NSESS*NCLOCK, exp_tog: NSESS-1, exp_init: NSESS, exp_pass: 1'b1};
    vecs[1] = '{bad:  2, mid_start: 1'b0, exp_run: NSESS*NCLOCK, exp_tog: NSESS-1, exp_init: NSESS, exp_pass: 1'b0};
    vecs[2] = '{bad: -1, mid_start: 1'b1, exp_run: NSESS*NCLOCK, exp_tog: NSESS-1, exp_init: NSESS, exp_pass: 1'b1};
    vecs[3] = '{bad:  0, mid_start: 1'b0, exp_run: NSESS*NCLOCK, exp_tog: NSESS-1, exp_init: NSESS, exp_pass: 1'b0};
    vecs[4] = '{bad:  3, mid_start: 1'b1, exp_run: NSESS*NCLOCK, exp_tog: NSESS-1, exp_init: NSESS, exp_pass: 1'b0};

    bus.start = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    #2 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 check_all_zero("idle");

    // Table runs; every run after the first restarts from DONE.
    for (int i = 0; i < 5; i++) begin
      bad_sess = vecs[i].bad;
      do_start(1'b1, vecs[i].exp_pass);
      if (vecs[i].mid_start) begin
        repeat (3) @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("mid_start_running", int'(bus.running), 1);
        check("mid_start_no_init", int'(bus.init), 0);
      end
      wait_done(vecs[i].exp_run, vecs[i].exp_tog, vecs[i].exp_init, vecs[i].exp_pass);
    end

    // Mid-run reset: asynchronous, outputs drop before the next edge.
    bad_sess = -1;
    do_start(1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check_all_zero("midreset");
    @(posedge clk);
    #3 reset_n = 1'b1;
    do_start(1'b1, 1'b1);
    wait_done(NSESS*NCLOCK, NSESS-1, NSESS, 1'b1);

    // Reset/start overlap: run begins on the first edge after release.
    @(posedge clk);
    #1 reset_n = 1'b0;
    bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    clear_counts();
    start_edge = cyc + 1;
    exp_q.push_back({1'b1, 31'(LAT)});
    #1 check("overlap_pre_init", int'(bus.init), 0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("overlap_init", int'(bus.init), 1);
    wait_done(NSESS*NCLOCK, NSESS-1, NSESS, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
